// File: rtl/sha_rb_pkg.sv
// Shared definitions for the SHA-256 digest read-back engine.
// Holds the FSM state encoding and the word/byte geometry constants.
package sha_rb_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_WAIT = S_WAIT,
    ST_SEND = S_SEND,
    ST_DONE = S_DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DIGEST_WORDS   = 8;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one 32-bit word and emits it MSB byte first over valid/ready.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   load_i          - capture load_data_i, restart byte count, raise valid
//   load_data_i     - 32-bit word to serialise
//   out_ready_i     - sink ready
//   out_data_o      - current byte (top of shift register)
//   out_valid_o     - byte valid
//   byte_cnt_o      - index of the byte currently presented (0..3)
//   word_done_o     - high in the cycle the 4th byte is accepted
module word_byte_serializer
  import sha_rb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic [1:0]  byte_cnt_o,
  output logic        word_done_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic        valid_q;
  logic        fire_s;

  // Handshake decode.
  always_comb begin
    fire_s      = valid_q && out_ready_i;
    word_done_o = fire_s && (cnt_q == LAST_BYTE);
  end

  // Shift register, byte counter and valid flag; all hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= 32'h0000_0000;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= load_data_i;
      cnt_q   <= 2'd0;
      valid_q <= 1'b1;
    end else if (fire_s) begin
      shift_q <= {shift_q[23:0], 8'h00};
      cnt_q   <= cnt_q + 2'd1;
      if (cnt_q == LAST_BYTE) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
      end
    end else begin
      shift_q <= shift_q;
      cnt_q   <= cnt_q;
      valid_q <= valid_q;
    end
  end

  assign out_data_o  = shift_q[31:24];
  assign out_valid_o = valid_q;
  assign byte_cnt_o  = cnt_q;

endmodule

// File: rtl/sha_digest_reader.sv
// Digest read-back engine: on start, reads NUM_WORDS words from data
// memory starting at BASE_ADDR and streams them big-endian, one byte per
// valid/ready transfer.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   start                - one-cycle request, honoured only when idle
//   busy, done           - run in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr  - synchronous read request to data memory
//   mem_rdata            - read data, valid the cycle after the request
//   out_data, out_valid, out_ready, out_last - byte stream
module sha_digest_reader
  import sha_rb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = DIGEST_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [7:0]        LAST_IDX  = 8'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e            state_q;
  logic [7:0]        idx_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;

  logic [7:0]        idx_d;
  logic [ADDR_W-1:0] addr_d;
  logic              load_s;
  logic [1:0]        byte_cnt_s;
  logic              word_done_s;

  // Next word index and its address; the add wraps at 2^ADDR_W.
  always_comb begin
    idx_d  = idx_q + 8'd1;
    addr_d = BASE_A + ADDR_W'(idx_d);
    load_s = (state_q == ST_WAIT);
  end

  // Control FSM with registered status and memory-request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            idx_q   <= 8'd0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addr_q  <= BASE_A;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          rd_en_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Serializer captures mem_rdata on this edge via load_s.
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (word_done_s) begin
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_d;
              rd_en_q <= 1'b1;
              addr_q  <= addr_d;
              state_q <= ST_REQ;
            end
          end else begin
            state_q <= ST_SEND;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  word_byte_serializer u_ser (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load_s),
    .load_data_i (mem_rdata),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .byte_cnt_o  (byte_cnt_s),
    .word_done_o (word_done_s)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  // Decoded purely from registers, so it is glitch-free and stall-stable.
  assign out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX) &&
                     (byte_cnt_s == LAST_BYTE);

endmodule
